weight_bank_sched: RTL and testbench

- Controller for the four weight_memory banks in front of the PE array.
- Load phase: accepts a per-layer byte stream and writes it round-robin across the banks. Byte k goes to bank k%4 at address k/4.
- Read phase: issues a burst of common read addresses to all four banks, so each cycle delivers 4 weights (one per bank) to the PEs.
- Sequences the layer index (layer2weight_cnt) and bank chip-selects.

---
 rtl/weight_bank_sched_if.sv | 30 +++
 rtl/weight_bank_sched.sv | 137 +++++++++++++
 tb/tb_weight_bank_sched.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_bank_sched_if.sv
// Weight stream and bank-side bus of the weight bank scheduler.
// The master modport is the scheduler; the slave modport is the stream source and banks.
interface weight_bank_sched_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic [3:0]            mem_csen;
    logic [3:0]            mem_wrenb;
    logic [ADDR_WIDTH-1:0] mem_addr_b;
    logic [DATA_WIDTH-1:0] mem_data_b;
    logic [3:0]            layer2weight_cnt;
    logic                  mem_rdena;
    logic [ADDR_WIDTH-1:0] mem_addr_a;
    logic                  rd_data_valid;

    modport master (
        input  s_valid, s_data,
        output s_ready, mem_csen, mem_wrenb, mem_addr_b, mem_data_b,
               layer2weight_cnt, mem_rdena, mem_addr_a, rd_data_valid
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready, mem_csen, mem_wrenb, mem_addr_b, mem_data_b,
               layer2weight_cnt, mem_rdena, mem_addr_a, rd_data_valid
    );
endinterface

// File: rtl/weight_bank_sched.sv
// Weight bank scheduler: round-robin byte loader into four banks and
// common-address read burst issuer for the PE array.
module weight_bank_sched #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BANKS  = 4,
    parameter int BANK_DEPTH = 2048
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  layer_start,
    input  logic [3:0]            layer_id,
    input  logic [13:0]           wt_len,
    input  logic                  rd_start,
    input  logic [ADDR_WIDTH-1:0] rd_base,
    input  logic [11:0]           rd_cnt,
    output logic                  load_done,
    output logic                  rd_done,
    output logic                  busy,
    output logic                  err,
    weight_bank_sched_if.master   bus
);

    localparam logic [13:0]           MAX_LEN  = 14'(NUM_BANKS * BANK_DEPTH);
    localparam logic [11:0]           MAX_RD   = 12'(BANK_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, LOAD, READY, READ} state_t;

    state_t      state_q, state_d;
    logic [13:0] k_q, len_q;
    logic [11:0] remain_q;

    logic idle_rdy, ls_ok, rd_ok, rd_go, hs, load_last, rd_last, err_set;

    assign idle_rdy  = (state_q == IDLE) || (state_q == READY);
    assign ls_ok     = layer_start && idle_rdy && (wt_len <= MAX_LEN);
    // layer_start has priority over a coincident rd_start
    assign rd_ok     = rd_start && !layer_start && (state_q == READY) && (rd_cnt <= MAX_RD);
    assign rd_go     = rd_ok && (rd_cnt != '0);
    assign hs        = bus.s_valid && bus.s_ready;
    assign load_last = (state_q == LOAD) && (k_q == len_q);
    assign rd_last   = (state_q == READ) && bus.mem_rdena && (remain_q == '0);
    assign err_set   = (layer_start && idle_rdy && (wt_len > MAX_LEN))
                     || (rd_start && (state_q == READY) && (layer_start || (rd_cnt > MAX_RD)))
                     || (busy && (layer_start || rd_start));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, READY: begin
                if (ls_ok)      state_d = (wt_len == '0) ? READY : LOAD;
                else if (rd_go) state_d = READ;
            end
            LOAD:    if (load_last) state_d = READY;
            READ:    if (rd_last)   state_d = READY;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q == LOAD) || (state_q == READ);
        bus.s_ready = (state_q == LOAD) && (k_q != len_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q                  <= '0;
            len_q                <= '0;
            remain_q             <= '0;
            load_done            <= 1'b0;
            rd_done              <= 1'b0;
            err                  <= 1'b0;
            bus.mem_csen         <= '0;
            bus.mem_wrenb        <= '0;
            bus.mem_addr_b       <= '0;
            bus.mem_data_b       <= '0;
            bus.layer2weight_cnt <= '0;
            bus.mem_rdena        <= 1'b0;
            bus.mem_addr_a       <= '0;
            bus.rd_data_valid    <= 1'b0;
        end else begin
            load_done         <= 1'b0;
            rd_done           <= 1'b0;
            bus.mem_csen      <= '0;
            bus.mem_wrenb     <= '0;
            bus.mem_rdena     <= 1'b0;
            bus.rd_data_valid <= bus.mem_rdena;

            if (err_set) err <= 1'b1;

            if (ls_ok) begin
                bus.layer2weight_cnt <= layer_id;
                k_q                  <= '0;
                len_q                <= wt_len;
                load_done            <= (wt_len == '0);
            end

            if (rd_ok && (rd_cnt == '0)) rd_done <= 1'b1;

            if (rd_go) begin
                bus.mem_rdena  <= 1'b1;
                bus.mem_csen   <= '1;
                bus.mem_addr_a <= rd_base;
                remain_q       <= rd_cnt - 12'd1;
            end

            // rd_done lands with the last valid, one cycle after the last address
            if ((state_q == READ) && bus.mem_rdena) begin
                if (remain_q != '0) begin
                    bus.mem_rdena  <= 1'b1;
                    bus.mem_csen   <= '1;
                    bus.mem_addr_a <= bus.mem_addr_a + ADDR_ONE;
                    remain_q       <= remain_q - 12'd1;
                end else begin
                    rd_done <= 1'b1;
                end
            end

            if (hs) begin
                bus.mem_csen   <= 4'b0001 << k_q[1:0];
                bus.mem_wrenb  <= 4'b0001 << k_q[1:0];
                bus.mem_addr_b <= k_q[ADDR_WIDTH+1:2];
                bus.mem_data_b <= DATA_WIDTH'(bus.s_data);
                k_q            <= k_q + 14'd1;
            end

            if (load_last) load_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_weight_bank_sched.sv
// Scoreboard bench for weight_bank_sched: directed stimulus queues expected
// bank writes, read addresses, read data and done pulses; a monitor checks them.
module tb_weight_bank_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        layer_start, rd_start;
    logic [3:0]  layer_id;
    logic [13:0] wt_len;
    logic [10:0] rd_base;
    logic [11:0] rd_cnt;
    logic        load_done, rd_done, busy, err;

    always #5 clk = ~clk;

    weight_bank_sched_if #(.ADDR_WIDTH(11), .DATA_WIDTH(8)) bus ();

    weight_bank_sched #(
        .ADDR_WIDTH(11), .DATA_WIDTH(8), .NUM_BANKS(4), .BANK_DEPTH(2048)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .layer_start(layer_start), .layer_id(layer_id), .wt_len(wt_len),
        .rd_start(rd_start), .rd_base(rd_base), .rd_cnt(rd_cnt),
        .load_done(load_done), .rd_done(rd_done), .busy(busy), .err(err),
        .bus(bus)
    );

    typedef struct packed {logic [3:0] cs; logic [10:0] addr; logic [7:0] data;} wr_t;
    typedef struct packed {logic [31:0] word; logic last;} rd_t;
    typedef struct packed {logic [3:0] id; logic wr;} ld_t;

    wr_t         wq[$];
    logic [10:0] aq[$];
    rd_t         dq[$];
    ld_t         lq[$];
    int          zq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_wr = 0;

    // Bank model: unwritten word at address a in bank b holds (4a+b) mod 256
    logic [7:0]  bank [4][2048];
    logic [31:0] data_a;
    logic        init_done = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!init_done) begin
            for (int b = 0; b < 4; b++)
                for (int a = 0; a < 2048; a++)
                    bank[b][a] <= 8'(a * 4 + b);
            init_done <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_wrenb[b]) bank[b][bus.mem_addr_b] <= bus.mem_data_b;
                if (bus.mem_rdena) data_a[b*8 +: 8] <= bank[b][bus.mem_addr_a];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic unexp(input string name);
        checks++;
        errors++;
        $display("FAIL unexpected_%s actual=event required=none", name);
    endtask

    function automatic logic [63:0] outs();
        return 64'({busy, err, load_done, rd_done, bus.s_ready, bus.mem_csen, bus.mem_wrenb,
                    bus.mem_rdena, bus.rd_data_valid, bus.layer2weight_cnt,
                    bus.mem_addr_a, bus.mem_addr_b, bus.mem_data_b});
    endfunction

    function automatic logic [31:0] pat(input int a);
        return {8'(a*4+3), 8'(a*4+2), 8'(a*4+1), 8'(a*4)};
    endfunction

    // Monitor
    initial forever begin
        wr_t w; rd_t d; ld_t l; logic [10:0] a; int z;
        @(negedge clk);
        if (rst_n) begin
            if (bus.mem_wrenb != 4'h0 || (bus.mem_csen != 4'h0 && !bus.mem_rdena)) begin
                if (wq.size() == 0) unexp("write");
                else begin
                    w = wq.pop_front();
                    chk("wr_bus", {bus.mem_csen, bus.mem_wrenb, bus.mem_addr_b, bus.mem_data_b},
                        {w.cs, w.cs, w.addr, w.data});
                    last_wr = cyc;
                end
            end
            if (bus.mem_rdena) begin
                if (aq.size() == 0) unexp("rdena");
                else begin
                    a = aq.pop_front();
                    chk("rd_addr", {bus.mem_csen, bus.mem_wrenb, bus.mem_addr_a}, {4'hf, 4'h0, a});
                end
            end
            if (bus.rd_data_valid) begin
                if (dq.size() == 0) unexp("rd_valid");
                else begin
                    d = dq.pop_front();
                    chk("rd_data", {data_a, rd_done}, {d.word, d.last});
                end
            end else if (rd_done) begin
                if (zq.size() == 0) unexp("rd_done");
                else begin
                    z = zq.pop_front();
                    chk("rd_done_zero", {busy, bus.mem_rdena}, 2'b00);
                end
            end
            if (load_done) begin
                if (lq.size() == 0) unexp("load_done");
                else begin
                    l = lq.pop_front();
                    chk("ld_layer", {bus.layer2weight_cnt, bus.s_ready, busy}, {l.id, 1'b0, 1'b0});
                    if (l.wr) chk("ld_latency", cyc, last_wr + 1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] id, input logic [13:0] len);
        layer_start = 1'b1; layer_id = id; wt_len = len;
        tick();
        layer_start = 1'b0;
    endtask

    task automatic rd(input logic [10:0] base, input logic [11:0] cnt);
        rd_start = 1'b1; rd_base = base; rd_cnt = cnt;
        tick();
        rd_start = 1'b0;
    endtask

    task automatic push_wr(input int k, input logic [7:0] d);
        wr_t w;
        w.cs = 4'b0001 << (k % 4); w.addr = 11'(k / 4); w.data = d;
        wq.push_back(w);
    endtask

    task automatic push_ld(input logic [3:0] id, input logic wr);
        ld_t l;
        l.id = id; l.wr = wr;
        lq.push_back(l);
    endtask

    task automatic push_rd(input logic [10:0] a, input logic [31:0] word, input logic last);
        rd_t d;
        d.word = word; d.last = last;
        aq.push_back(a);
        dq.push_back(d);
    endtask

    task automatic send(input logic [7:0] d);
        logic ok;
        int n = 0;
        bus.s_valid = 1'b1; bus.s_data = d;
        do begin
            ok = bus.s_ready;
            tick();
            n++;
        end while (!ok && n < 50);
        chk("hs_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        layer_start = 0; rd_start = 0; layer_id = 0; wt_len = 0; rd_base = 0; rd_cnt = 0;
        bus.s_valid = 0; bus.s_data = 0;
        #2;
        chk("reset_outs", outs(), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Oversized layer: flagged, nothing loaded
        do_load(4'd1, 14'd9000);
        tick();
        chk("oversize", {err, busy, bus.layer2weight_cnt}, {1'b1, 1'b0, 4'd0});
        pulse_reset();
        chk("err_cleared", 64'(err), 64'd0);

        // Layer 2, 8 bytes back-to-back
        push_ld(4'd2, 1'b1);
        for (int k = 0; k < 8; k++) push_wr(k, 8'(8'h10 + k));
        do_load(4'd2, 14'd8);
        for (int k = 0; k < 8; k++) send(8'(8'h10 + k));
        bus.s_valid = 1'b0;
        wait_idle();
        chk("after_load", {err, bus.s_ready, bus.layer2weight_cnt}, {1'b0, 1'b0, 4'd2});
        tick();

        push_rd(11'd0, 32'h13121110, 1'b0);
        push_rd(11'd1, 32'h17161514, 1'b1);
        rd(11'd0, 12'd2);
        wait_idle();
        tick();

        // Address wrap 2046 -> 1
        push_rd(11'd2046, 32'hFBFAF9F8, 1'b0);
        push_rd(11'd2047, 32'hFFFEFDFC, 1'b0);
        push_rd(11'd0,    32'h13121110, 1'b0);
        push_rd(11'd1,    32'h17161514, 1'b1);
        rd(11'd2046, 12'd4);
        wait_idle();
        tick();

        zq.push_back(0);
        rd(11'd5, 12'd0);
        repeat (3) tick();
        chk("zero_rd", {err, busy}, 2'b00);

        push_ld(4'd5, 1'b0);
        do_load(4'd5, 14'd0);
        repeat (3) tick();

        // Layer 3 with stream gaps and an illegal rd_start mid-load
        push_ld(4'd3, 1'b1);
        for (int k = 0; k < 6; k++) push_wr(k, 8'(8'h20 + k));
        do_load(4'd3, 14'd6);
        for (int k = 0; k < 6; k++) begin
            send(8'(8'h20 + k));
            bus.s_valid = 1'b0;
            rd_start = (k == 2);
            if (k < 5) chk("gap_ready", 64'(bus.s_ready), 64'd1);
            tick();
            rd_start = 1'b0;
        end
        wait_idle();
        chk("load_err", {err, bus.layer2weight_cnt}, {1'b1, 4'd3});
        tick();

        push_rd(11'd0, 32'h23222120, 1'b0);
        push_rd(11'd1, 32'h17162524, 1'b1);
        rd(11'd0, 12'd2);
        wait_idle();
        tick();

        pulse_reset();
        chk("reset2", {err, busy, bus.layer2weight_cnt}, 6'd0);
        push_ld(4'd6, 1'b0);
        do_load(4'd6, 14'd0);
        repeat (2) tick();

        // Simultaneous layer_start and rd_start in READY
        push_ld(4'd7, 1'b1);
        for (int k = 0; k < 4; k++) push_wr(k, 8'(8'h30 + k));
        layer_start = 1'b1; rd_start = 1'b1; layer_id = 4'd7; wt_len = 14'd4;
        rd_base = 11'd0; rd_cnt = 12'd2;
        tick();
        layer_start = 1'b0; rd_start = 1'b0;
        chk("simul", {busy, err, bus.s_ready}, 3'b111);
        for (int k = 0; k < 4; k++) send(8'(8'h30 + k));
        bus.s_valid = 1'b0;
        wait_idle();
        tick();

        // Reset in the middle of a 10-word burst
        push_rd(11'd0, 32'h33323130, 1'b0);
        push_rd(11'd1, 32'h17162524, 1'b0);
        for (int i = 2; i < 10; i++) push_rd(11'(i), pat(i), i == 9);
        rd(11'd0, 12'd10);
        tick(); tick();
        chk("mid_read", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_outs", outs(), 64'd0);
        aq.delete();
        dq.delete();
        tick(); tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("abort_idle", {busy, err, rd_done}, 3'b000);

        repeat (3) tick();
        chk("pending", 64'(wq.size() + aq.size() + dq.size() + lq.size() + zq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
